// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types, requester count and arbitration helper for mul_sched
package mul_pkg;

    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot pick among two requesters; ptr breaks the tie when both ask.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] valid, input logic ptr);
        logic [NREQ-1:0] g;
        g = valid;
        if (&valid) begin
            g = ptr ? 2'b10 : 2'b01;
        end
        return g;
    endfunction

endpackage

// File: rtl/mul_sched_if.sv
// rtl/mul_sched_if.sv - request/response bundle between requesters, consumer and mul_sched
interface mul_sched_if import mul_pkg::*; #(parameter int W = 4);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0][W-1:0] req_a;
    logic [NREQ-1:0][W-1:0] req_b;
    logic [NREQ-1:0]        req_ready;
    logic                   rsp_valid;
    logic                   rsp_id;
    logic [2*W-1:0]         rsp_p;
    logic                   rsp_ready;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p, busy
    );

endinterface

// File: rtl/mul_seq_core.sv
// rtl/mul_seq_core.sv - shift-add multiplier datapath, one iteration per step
module mul_seq_core #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] acc,
    output logic           done
);

    localparam int CW = $clog2(W) + 1;

    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    // Load operands on acceptance, then add-and-shift once per step; W steps always run.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    // High while the step in progress is the last of the W iterations.
    assign done = (cnt == CW'(W - 1));

endmodule

// File: rtl/mul_sched.sv
// rtl/mul_sched.sv - round-robin scheduler sharing one shift-add multiplier between two requesters
module mul_sched import mul_pkg::*; #(
    parameter int W = 4
) (
    input  logic       clk,
    input  logic       rst,
    mul_sched_if.slave bus
);

    state_t          state;
    logic            rr_ptr;
    logic            rsp_valid_r;
    logic            rsp_id_r;
    logic            busy_r;
    logic [NREQ-1:0] grant;
    logic            load;
    logic            step;
    logic            core_done;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [2*W-1:0]  acc;

    // Grant only in IDLE and never while reset is asserted; operands follow the grant.
    always_comb begin
        grant = '0;
        if (!rst && state == IDLE) begin
            grant = rr_pick(bus.req_valid, rr_ptr);
        end
        sel_a = grant[1] ? bus.req_a[1] : bus.req_a[0];
        sel_b = grant[1] ? bus.req_b[1] : bus.req_b[0];
    end

    assign load = |grant;
    assign step = (state == CALC);

    mul_seq_core #(.W(W)) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .a    (sel_a),
        .b    (sel_b),
        .acc  (acc),
        .done (core_done)
    );

    // Control FSM: accept, iterate W cycles, hold the product until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        state    <= CALC;
                        busy_r   <= 1'b1;
                        rsp_id_r <= grant[1];
                        rr_ptr   <= ~grant[1];
                    end
                end
                CALC: begin
                    if (core_done) begin
                        state       <= DONE;
                        rsp_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_p     = acc;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mul_sched.sv
// tb/tb_mul_sched.sv - scoreboard bench for mul_sched
module tb_mul_sched;
    import mul_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic           id;
        logic [2*W-1:0] p;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    logic prev_rv = 1'b0;

    rsp_t       exp_rsp[$];
    logic [1:0] exp_grant[$];

    always #5 clk = ~clk;

    mul_sched_if #(.W(W)) bus ();

    mul_sched #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] x;
        logic [2*W-1:0] y;
        x = {{W{1'b0}}, a};
        y = {{W{1'b0}}, b};
        return x * y;
    endfunction

    task automatic expect_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        rsp_t r;
        r.id = id;
        r.p  = prod(a, b);
        exp_grant.push_back(id ? 2'b10 : 2'b01);
        exp_rsp.push_back(r);
    endtask

    task automatic wait_grants();
        int n = 0;
        while (exp_grant.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (exp_grant.size() != 0) begin
            chk("grant_timeout", exp_grant.size(), 0);
            exp_grant.delete();
        end
    endtask

    task automatic wait_rsps();
        int n = 0;
        while (exp_rsp.size() != 0 && n < 120) begin
            @(posedge clk);
            n++;
        end
        if (exp_rsp.size() != 0) begin
            chk("rsp_timeout", exp_rsp.size(), 0);
            exp_rsp.delete();
        end
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            prev_rv = 1'b0;
        end else begin
            if (bus.req_ready != 2'b00) begin
                if (exp_grant.size() == 0) chk("grant_unexpected", bus.req_ready, 0);
                else chk("grant", bus.req_ready, exp_grant.pop_front());
                accept_cyc = cyc + 1;
            end
            if (bus.rsp_valid && !prev_rv) chk("latency", cyc - accept_cyc, W);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_valid, 0);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_id", bus.rsp_id, e.id);
                    chk("rsp_p", bus.rsp_p, e.p);
                end
            end
            prev_rv = bus.rsp_valid;
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         ri;
        int           n;

        bus.req_valid = 2'b11;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_p", bus.rsp_p, 0);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // both requesters continuously valid: grants alternate starting at 0
        expect_op(1'b0, 4'd3, 4'd5);
        expect_op(1'b1, 4'd9, 4'd6);
        expect_op(1'b0, 4'd3, 4'd5);
        expect_op(1'b1, 4'd9, 4'd6);
        bus.req_a[0] = 4'd3; bus.req_b[0] = 4'd5;
        bus.req_a[1] = 4'd9; bus.req_b[1] = 4'd6;
        bus.req_valid = 2'b11;
        wait_grants();
        #1 bus.req_valid = 2'b00;
        wait_rsps();

        // single requester 7x6, operands disturbed after acceptance
        expect_op(1'b0, 4'd7, 4'd6);
        bus.req_a[0] = 4'd7; bus.req_b[0] = 4'd6;
        bus.req_valid = 2'b01;
        wait_grants();
        #1;
        bus.req_valid = 2'b00;
        bus.req_a[0] = 4'd15; bus.req_b[0] = 4'd15;
        wait_rsps();

        // zero multiplier and maximum operands
        expect_op(1'b1, 4'd2, 4'd0);
        bus.req_a[1] = 4'd2; bus.req_b[1] = 4'd0;
        bus.req_valid = 2'b10;
        wait_grants();
        #1 bus.req_valid = 2'b00;
        wait_rsps();
        expect_op(1'b0, 4'd15, 4'd15);
        bus.req_a[0] = 4'd15; bus.req_b[0] = 4'd15;
        bus.req_valid = 2'b01;
        wait_grants();
        #1 bus.req_valid = 2'b00;
        wait_rsps();

        // consumer stalls three cycles in DONE while both requesters ask
        bus.rsp_ready = 1'b0;
        expect_op(1'b1, 4'd11, 4'd13);
        bus.req_a[1] = 4'd11; bus.req_b[1] = 4'd13;
        bus.req_valid = 2'b10;
        wait_grants();
        #1 bus.req_valid = 2'b11;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            chk("hold_rsp_valid", bus.rsp_valid, 1);
            chk("hold_rsp_p", bus.rsp_p, 143);
            chk("hold_rsp_id", bus.rsp_id, 1);
            chk("hold_req_ready", bus.req_ready, 0);
            chk("hold_busy", bus.busy, 1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        wait_rsps();

        // reset in the second CALC cycle aborts the operation and clears the pointer
        exp_grant.push_back(2'b01);
        bus.req_a[0] = 4'd5; bus.req_b[0] = 4'd5;
        bus.req_valid = 2'b01;
        wait_grants();
        #1 bus.req_valid = 2'b00;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_ready", bus.req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_rsp_p", bus.rsp_p, 0);
        @(posedge clk);
        #1;
        expect_op(1'b0, 4'd3, 4'd3);
        bus.req_a[0] = 4'd3; bus.req_b[0] = 4'd3;
        bus.req_a[1] = 4'd4; bus.req_b[1] = 4'd4;
        bus.req_valid = 2'b11;
        wait_grants();
        #1 bus.req_valid = 2'b00;
        wait_rsps();

        // random single-requester operations
        for (int k = 0; k < 6; k++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            ri = 1'($urandom_range(0, 1));
            expect_op(ri, ra, rb);
            bus.req_a[ri] = ra;
            bus.req_b[ri] = rb;
            bus.req_a[~ri] = ~ra;
            bus.req_b[~ri] = ~rb;
            bus.req_valid = ri ? 2'b10 : 2'b01;
            wait_grants();
            #1 bus.req_valid = 2'b00;
            wait_rsps();
        end

        repeat (10) @(posedge clk);
        #1;
        chk("left_rsp", exp_rsp.size(), 0);
        chk("left_grant", exp_grant.size(), 0);
        chk("final_busy", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 Parameter: W, 4, operand width; product width 2W; iteration count W.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  2  per-requester operation request; bit i = requester i.
REQ-005 req_a  input  2xW  per-requester multiplicand.
REQ-006 req_b  input  2xW  per-requester multiplier.
REQ-007 req_ready  output  2  per-requester grant; at most one bit high.
REQ-008 rsp_valid  output  1  product available.
REQ-009 rsp_id  output  1  index of the requester that owns the product.
REQ-010 rsp_p  output  2W  product.
REQ-011 rsp_ready  input  1  consumer accepts the product.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block shall share one shift-add multiplier between two requesters; an operation is accepted on an edge where req_valid[i] && req_ready[i].
REQ-014 The FSM shall have exactly three states: IDLE, CALC, DONE.
REQ-015 req_ready shall be combinational and asserted only in IDLE, to exactly one requester with req_valid high.
REQ-016 Arbitration shall be round-robin: rr_ptr selects the preferred requester; if only one is valid, that one is granted; after a grant to i, rr_ptr shall become 1-i.
REQ-017 IDLE->CALC on acceptance: capture a into the 2W-bit zero-extended mcand, b into mplier, clear acc, record rsp_id, clear the iteration counter.
REQ-018 Each CALC cycle: if mplier[0], acc <= acc + mcand; mcand <<= 1; mplier >>= 1; counter increments.
REQ-019 CALC shall last exactly W cycles regardless of operand values (b=0 included), with no early termination.
REQ-020 CALC->DONE after the W-th iteration; rsp_valid shall be high W cycles after the acceptance edge.
REQ-021 In DONE, rsp_valid=1 and rsp_p=acc; rsp_id and rsp_p shall be held stable until rsp_ready.
REQ-022 DONE->IDLE on the edge with rsp_ready=1; no new request shall be accepted in the same cycle.
REQ-023 Minimum issue interval is W+2 cycles (accept, W CALC, 1 DONE).
REQ-024 Arithmetic shall be unsigned and exact; 2W bits never overflow ((2^W-1)^2 fits).
REQ-025 Request inputs shall be ignored outside IDLE; changes to req_a/req_b after acceptance shall not affect the result.

Reset
REQ-026 On rst: state=IDLE, rr_ptr=0, acc=0, counter=0, rsp_id=0, rsp_valid=0, busy=0, req_ready=0 during the reset cycle.
REQ-027 Reset during CALC or DONE shall discard the operation with no response produced; rst overrides all other inputs.

Structure
REQ-028 A shared package mul_pkg shall hold the state typedef (IDLE/CALC/DONE) and NREQ=2.
REQ-029 The datapath (acc/mcand/mplier/counter, REQ-017..019) shall be a sub-module mul_seq_core with load/step controls and a done flag; arbitration and the FSM stay in mul_sched.

Verification
REQ-030 Requester 0 only, a=7, b=6 -> req_ready=01 in the accept cycle; rsp_p=42, rsp_id=0, rsp_valid 4 cycles later.
REQ-031 Both valid continuously: req0 (3x5) and req1 (9x6) -> responses in order id0=15, id1=54, id0=15, id1=54; grants alternate.
REQ-032 a=2, b=0 -> rsp_p=0 after exactly 4 CALC cycles; a=15, b=15 -> 225.
REQ-033 rsp_ready held low 3 cycles in DONE -> rsp_valid, rsp_p and rsp_id stable; req_ready=00 and busy=1 throughout.
REQ-034 rst pulsed in 2nd CALC cycle -> next cycle IDLE, busy=0, rsp_valid=0, rr_ptr=0; no response is ever emitted for the aborted operation.
